// File: rtl/clk_divider.sv
`timescale 1ns/1ps
// clk_divider: integer clock divider; odd ratios stretch the high phase by a
// falling-edge stage so the duty cycle is exactly 50 % in time.
module clk_divider #(
  parameter int DIV = 10,
  parameter int CW = $clog2(DIV)
) (
  input  logic ClkIn,
  input  logic rst,
  output logic ClkOut
);
  logic [CW-1:0] cnt, cntNext;
  logic p, n, armed, armedNext;
  if (DIV < 2) begin : gBadDiv
    $error("clk_divider: DIV must be at least 2");
  end
  // output stays low until the first wrap so the first rise lands on edge DIV
  always_comb begin
    cntNext = (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
    armedNext = armed | (cntNext == '0);
  end
  always_ff @(posedge ClkIn or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      p <= 1'b0;
      armed <= 1'b0;
    end else begin
      cnt <= cntNext;
      p <= armedNext && (cntNext < CW'(DIV / 2));
      armed <= armedNext;
    end
  end
  if (DIV % 2 == 1) begin : gOdd
    always_ff @(negedge ClkIn or negedge rst) begin
      if (!rst) n <= 1'b0;
      else n <= p;
    end
  end else begin : gEven
    assign n = 1'b0;
  end
  assign ClkOut = p | n;
endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps
// tb_clk_divider: scoreboard of expected ClkOut edge times for DIV = 10, 4, 3, 2
module tb_clk_divider;
  typedef struct {
    longint t;
    logic v;
  } ev_t;
  logic ClkIn = 1'b1;
  logic rst;
  logic [3:0] co;
  int compared = 0;
  int mismatched = 0;
  int rises = 0;
  int maxCnt = 0;
  bit done = 1'b0;
  ev_t q[4][$];
  int divs[4] = '{10, 4, 3, 2};
  int cnt4[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int co4[8] = '{0, 0, 0, 1, 1, 0, 0, 1};

  always #10 ClkIn = ~ClkIn;

  clk_divider #(.DIV(10)) u10 (.ClkIn(ClkIn), .rst(rst), .ClkOut(co[0]));
  clk_divider #(.DIV(4))  u4  (.ClkIn(ClkIn), .rst(rst), .ClkOut(co[1]));
  clk_divider #(.DIV(3))  u3  (.ClkIn(ClkIn), .rst(rst), .ClkOut(co[2]));
  clk_divider #(.DIV(2))  u2  (.ClkIn(ClkIn), .rst(rst), .ClkOut(co[3]));

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input longint t, input logic v);
    ev_t e;
    e.t = t;
    e.v = v;
    q[i].push_back(e);
  endtask

  // expected edges after a release whose first counted rising edge is at e1
  task automatic pushEv(input int i, input longint e1, input longint tEnd, input bit drop);
    int d = divs[i];
    logic last = 1'b0;
    for (longint r = e1 + longint'(d - 1) * 20; r < tEnd; r += longint'(d) * 20) begin
      longint f = r + longint'(d / 2) * 20 + ((d % 2 == 1) ? 10 : 0);
      push(i, r, 1'b1);
      last = 1'b1;
      if (f < tEnd) begin
        push(i, f, 1'b0);
        last = 1'b0;
      end
    end
    if (drop && last) push(i, tEnd, 1'b0);
  endtask

  task automatic mon(input int i);
    longint t = longint'($time);
    #1;
    if (!done) begin
      if (q[i].size() == 0) chk($sformatf("unexpected edge div%0d", divs[i]), t, -1);
      else begin
        ev_t e = q[i].pop_front();
        chk($sformatf("edge time div%0d", divs[i]), t, e.t);
        chk($sformatf("edge value div%0d", divs[i]), longint'(co[i]), longint'(e.v));
      end
    end
  endtask

  always @(co[0]) if ($time > 0) mon(0);
  always @(co[1]) if ($time > 0) mon(1);
  always @(co[2]) if ($time > 0) mon(2);
  always @(co[3]) if ($time > 0) mon(3);

  always @(posedge co[0]) if ($time > 355 && $time <= 20340) rises++;
  always @(negedge ClkIn) if (rst && int'(u10.cnt) > maxCnt) maxCnt = int'(u10.cnt);

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pushEv(i, 60, 285, 1'b1);
    #20 chk("reset co", longint'(co), 0);
    #20 chk("reset co", longint'(co), 0);
    #10 rst = 1'b1;
    #235 rst = 1'b0;
    for (int i = 0; i < 4; i++) pushEv(i, 360, 20405, 1'b0);
    #1;
    chk("async co", longint'(co), 0);
    chk("async cnt div10", longint'(u10.cnt), 0);
    chk("async cnt div4", longint'(u4.cnt), 0);
    chk("async n div3", longint'(u3.n), 0);
    #69 rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge ClkIn);
      #1;
      chk($sformatf("cnt div4 edge%0d", k + 1), longint'(u4.cnt), cnt4[k]);
      chk($sformatf("co div4 edge%0d", k + 1), longint'(co[1]), co4[k]);
    end
    #19904;
    done = 1'b1;
    for (int i = 0; i < 4; i++) chk($sformatf("missing edges div%0d", divs[i]), q[i].size(), 0);
    chk("rises in 1000 cycles", rises, 100);
    chk("max cnt div10", maxCnt, 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
